vdma_frame_sched: RTL and testbench

//  Frame-buffer scheduler for the VDMA: owns the N-frame ring in DDR, hands the AXI-MM writer (mm_tras)
//  and reader (mm_rev) their frame base addresses, and keeps the writer off the frame being read.

---
 rtl/vdma_frame_sched.sv | 165 ++++++++++++++++
 tb/tb_vdma_frame_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vdma_frame_sched.sv
// vdma_frame_sched: frame ring scheduler for the VDMA.
// It owns the N-frame ring in DDR and gives the AXI-MM writer and reader their frame base addresses.
// The reader always takes the newest completed frame, or repeats the frame it already has.
// The writer is always steered away from the frame the reader is using.
module vdma_frame_sched #(
  parameter int               ASIZE        = 29,
  parameter int               N_FRAMES     = 3,
  parameter logic [ASIZE-1:0] BASE_ADDR    = '0,
  parameter logic [ASIZE-1:0] FRAME_STRIDE = 'h100000,
  parameter int               CNT_W        = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             enable,
  input  logic             wr_start,
  input  logic             wr_done,
  input  logic             rd_start,
  input  logic             rd_done,
  output logic [ASIZE-1:0] wr_base_addr,
  output logic [2:0]       wr_idx,
  output logic             wr_busy,
  output logic [ASIZE-1:0] rd_base_addr,
  output logic [2:0]       rd_idx,
  output logic             rd_busy,
  output logic             rd_frame_valid,
  output logic             rd_new,
  output logic [CNT_W-1:0] wr_drop_cnt,
  output logic [CNT_W-1:0] rd_repeat_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e             wr_state_q, wr_state_d;
  state_e             rd_state_q, rd_state_d;
  logic [2:0]         wr_idx_q, wr_idx_d;
  logic [2:0]         rd_idx_q, rd_idx_d;
  logic [ASIZE-1:0]   wr_addr_q, rd_addr_q;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_new_q, rd_new_d;
  logic [2:0]         last_idx_q, last_idx_d;
  logic               last_vld_q, last_vld_d;
  logic               wr_first_q, wr_first_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;

  logic               wr_start_en, rd_start_en, wr_done_ev, rd_done_ev;
  logic               fwd_vld, rd_take, prot_vld, wr_drop;
  logic [2:0]         fwd_idx, cand0, cand;

  // Ring successor: N_FRAMES-1 wraps to 0.
  function automatic logic [2:0] nextIdx(input logic [2:0] i);
    return (i == 3'(N_FRAMES - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // Frame base address, truncated to the AXI address width.
  function automatic logic [ASIZE-1:0] addrOf(input logic [2:0] i);
    return BASE_ADDR + FRAME_STRIDE * ASIZE'(i);
  endfunction

  // Next-state decisions: writer completion is forwarded to a same-cycle reader start, the
  // reader chooses before the writer, and the writer skips whatever the reader protects.
  always_comb begin
    wr_start_en = wr_start & enable;
    rd_start_en = rd_start & enable;
    wr_done_ev  = wr_done & (wr_state_q == ACTIVE);
    rd_done_ev  = rd_done & (rd_state_q == ACTIVE);

    fwd_vld = last_vld_q | wr_done_ev;
    fwd_idx = wr_done_ev ? wr_idx_q : last_idx_q;
    rd_take = rd_start_en & fwd_vld;

    rd_idx_d   = rd_take ? fwd_idx : rd_idx_q;
    rd_valid_d = rd_take ? 1'b1 : rd_valid_q;
    rd_new_d   = rd_start_en ? rd_take : rd_new_q;

    rd_state_d = rd_state_q;
    if (rd_start_en) begin
      rd_state_d = ACTIVE;
    end else if (rd_done_ev) begin
      rd_state_d = IDLE;
    end

    rep_cnt_d = rep_cnt_q;
    if (rd_start_en && !rd_take && rd_valid_q && (rep_cnt_q != '1)) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end

    prot_vld = rd_start_en | (rd_state_q == ACTIVE);
    cand0    = wr_first_q ? 3'd0 : nextIdx(wr_idx_q);
    cand     = (prot_vld && (cand0 == rd_idx_d)) ? nextIdx(cand0) : cand0;

    wr_drop    = wr_start_en & (wr_state_q == ACTIVE) & ~wr_done_ev;
    wr_idx_d   = wr_start_en ? cand : wr_idx_q;
    wr_first_d = wr_start_en ? 1'b0 : wr_first_q;

    wr_state_d = wr_state_q;
    if (wr_start_en) begin
      wr_state_d = ACTIVE;
    end else if (wr_done_ev) begin
      wr_state_d = IDLE;
    end

    drop_cnt_d = drop_cnt_q;
    if (wr_drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    last_idx_d = wr_done_ev ? wr_idx_q : last_idx_q;
    last_vld_d = last_vld_q;
    if (rd_take) begin
      last_vld_d = 1'b0;
    end else if (wr_done_ev) begin
      last_vld_d = 1'b1;
    end
  end

  // Registered state for both FSMs, frame indices, addresses and statistics.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      wr_state_q <= IDLE;
      rd_state_q <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_new_q   <= 1'b0;
      last_idx_q <= '0;
      last_vld_q <= 1'b0;
      wr_first_q <= 1'b1;
      drop_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      if (wr_start_en) begin
        wr_addr_q <= addrOf(wr_idx_d);
      end
      if (rd_start_en) begin
        rd_addr_q <= addrOf(rd_idx_d);
      end
      rd_valid_q <= rd_valid_d;
      rd_new_q   <= rd_new_d;
      last_idx_q <= last_idx_d;
      last_vld_q <= last_vld_d;
      wr_first_q <= wr_first_d;
      drop_cnt_q <= drop_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign wr_base_addr   = wr_addr_q;
  assign wr_idx         = wr_idx_q;
  assign wr_busy        = (wr_state_q == ACTIVE);
  assign rd_base_addr   = rd_addr_q;
  assign rd_idx         = rd_idx_q;
  assign rd_busy        = (rd_state_q == ACTIVE);
  assign rd_frame_valid = rd_valid_q;
  assign rd_new         = rd_new_q;
  assign wr_drop_cnt    = drop_cnt_q;
  assign rd_repeat_cnt  = rep_cnt_q;

endmodule

// File: tb/tb_vdma_frame_sched.sv
// tb_vdma_frame_sched: directed vector bench for the frame scheduler.
// One instance uses the default 3-frame ring; a second uses a 4-frame ring with a 2 MiB stride.
module tb_vdma_frame_sched;

  localparam int ASIZE = 29;
  localparam int CNT_W = 16;

  logic             clk;
  logic             resetn;
  logic             enable, wrStart, wrDone, rdStart, rdDone;

  logic [ASIZE-1:0] wrAddr, rdAddr, wrAddr4, rdAddr4;
  logic [2:0]       wrIdx, rdIdx, wrIdx4, rdIdx4;
  logic             wrBusy, rdBusy, rdValid, rdNew;
  logic             wrBusy4, rdBusy4, rdValid4, rdNew4;
  logic [CNT_W-1:0] dropCnt, repCnt, dropCnt4, repCnt4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en, ws, wd, rs, rdn;
    logic [2:0] eWrIdx;
    logic       eWrBusy;
    logic [2:0] eRdIdx;
    logic       eRdBusy, eRdValid, eRdNew;
    int         eDrop, eRep;
  } vec_t;

  vec_t vecs[21];

  vdma_frame_sched dut (
    .axi_aclk(clk), .axi_resetn(resetn), .enable(enable),
    .wr_start(wrStart), .wr_done(wrDone), .rd_start(rdStart), .rd_done(rdDone),
    .wr_base_addr(wrAddr), .wr_idx(wrIdx), .wr_busy(wrBusy),
    .rd_base_addr(rdAddr), .rd_idx(rdIdx), .rd_busy(rdBusy),
    .rd_frame_valid(rdValid), .rd_new(rdNew),
    .wr_drop_cnt(dropCnt), .rd_repeat_cnt(repCnt)
  );

  vdma_frame_sched #(.N_FRAMES(4), .FRAME_STRIDE(29'h200000)) dut4 (
    .axi_aclk(clk), .axi_resetn(resetn), .enable(enable),
    .wr_start(wrStart), .wr_done(wrDone), .rd_start(rdStart), .rd_done(rdDone),
    .wr_base_addr(wrAddr4), .wr_idx(wrIdx4), .wr_busy(wrBusy4),
    .rd_base_addr(rdAddr4), .rd_idx(rdIdx4), .rd_busy(rdBusy4),
    .rd_frame_valid(rdValid4), .rd_new(rdNew4),
    .wr_drop_cnt(dropCnt4), .rd_repeat_cnt(repCnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and returns just after the next rising edge.
  task automatic applyStimulus(input logic en, input logic ws, input logic wd,
                               input logic rs, input logic rdn);
    @(negedge clk);
    enable  = en;
    wrStart = ws;
    wrDone  = wd;
    rdStart = rs;
    rdDone  = rdn;
    @(posedge clk);
    #1;
  endtask

  // Every output of the 3-frame instance must be zero.
  task automatic checkZero3(input string tag);
    checkOutput({tag, " wr_base_addr"}, 32'(wrAddr), 32'h0);
    checkOutput({tag, " wr_idx"}, 32'(wrIdx), 32'h0);
    checkOutput({tag, " wr_busy"}, 32'(wrBusy), 32'h0);
    checkOutput({tag, " rd_base_addr"}, 32'(rdAddr), 32'h0);
    checkOutput({tag, " rd_idx"}, 32'(rdIdx), 32'h0);
    checkOutput({tag, " rd_busy"}, 32'(rdBusy), 32'h0);
    checkOutput({tag, " rd_frame_valid"}, 32'(rdValid), 32'h0);
    checkOutput({tag, " rd_new"}, 32'(rdNew), 32'h0);
    checkOutput({tag, " wr_drop_cnt"}, 32'(dropCnt), 32'h0);
    checkOutput({tag, " rd_repeat_cnt"}, 32'(repCnt), 32'h0);
  endtask

  // Every output of the 4-frame instance must be zero.
  task automatic checkZero4(input string tag);
    checkOutput({tag, " n4 wr_base_addr"}, 32'(wrAddr4), 32'h0);
    checkOutput({tag, " n4 wr_idx"}, 32'(wrIdx4), 32'h0);
    checkOutput({tag, " n4 wr_busy"}, 32'(wrBusy4), 32'h0);
    checkOutput({tag, " n4 rd_base_addr"}, 32'(rdAddr4), 32'h0);
    checkOutput({tag, " n4 rd_idx"}, 32'(rdIdx4), 32'h0);
    checkOutput({tag, " n4 rd_busy"}, 32'(rdBusy4), 32'h0);
    checkOutput({tag, " n4 rd_frame_valid"}, 32'(rdValid4), 32'h0);
    checkOutput({tag, " n4 rd_new"}, 32'(rdNew4), 32'h0);
    checkOutput({tag, " n4 wr_drop_cnt"}, 32'(dropCnt4), 32'h0);
    checkOutput({tag, " n4 rd_repeat_cnt"}, 32'(repCnt4), 32'h0);
  endtask

  // Holds reset for two cycles with all inputs idle.
  task automatic applyReset();
    @(negedge clk);
    resetn  = 1'b0;
    enable  = 1'b0;
    wrStart = 1'b0;
    wrDone  = 1'b0;
    rdStart = 1'b0;
    rdDone  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    string tag;
    resetn  = 1'b0;
    enable  = 1'b0;
    wrStart = 1'b0;
    wrDone  = 1'b0;
    rdStart = 1'b0;
    rdDone  = 1'b0;

    // Hand-computed vectors for the 3-frame ring (stride 0x100000).
    //                en   ws   wd   rs   rdn  wIdx wB   rIdx rB   rV   rN   drop rep
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd0,1'b1, 3'd0,1'b0,1'b0,1'b0, 0, 0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b1, 3'd0,1'b0,1'b0,1'b0, 0, 0};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd0,1'b0, 3'd0,1'b0,1'b0,1'b0, 0, 0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd0,1'b0, 3'd0,1'b1,1'b1,1'b1, 0, 0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd1,1'b1, 3'd0,1'b1,1'b1,1'b1, 0, 0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd1,1'b0, 3'd0,1'b1,1'b1,1'b1, 0, 0};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd2,1'b1, 3'd0,1'b1,1'b1,1'b1, 0, 0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 3'd2,1'b0, 3'd2,1'b1,1'b1,1'b1, 0, 0};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b1, 0, 0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 3'd0,1'b1, 3'd2,1'b0,1'b1,1'b1, 0, 0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b0, 0, 1};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b0, 0, 2};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b0, 0, 3};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b0, 0, 3};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0,1'b1, 3'd2,1'b0,1'b1,1'b0, 0, 3};
    vecs[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd1,1'b1, 3'd2,1'b0,1'b1,1'b0, 1, 3};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b1, 3'd2,1'b1,1'b1,1'b0, 1, 4};
    vecs[17] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 3'd0,1'b1, 3'd2,1'b1,1'b1,1'b0, 1, 4};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd0,1'b1, 3'd1,1'b1,1'b1,1'b1, 1, 4};
    vecs[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd0,1'b0, 3'd1,1'b1,1'b1,1'b1, 1, 4};
    vecs[20] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 3'd1,1'b1, 3'd0,1'b1,1'b1,1'b1, 1, 4};

    applyReset();
    checkZero3("reset");

    // Table-driven section on the 3-frame instance.
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].en, vecs[i].ws, vecs[i].wd, vecs[i].rs, vecs[i].rdn);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, " wr_idx"}, 32'(wrIdx), 32'(vecs[i].eWrIdx));
      checkOutput({tag, " wr_busy"}, 32'(wrBusy), 32'(vecs[i].eWrBusy));
      checkOutput({tag, " wr_base_addr"}, 32'(wrAddr), 32'(vecs[i].eWrIdx) * 32'h100000);
      checkOutput({tag, " rd_idx"}, 32'(rdIdx), 32'(vecs[i].eRdIdx));
      checkOutput({tag, " rd_busy"}, 32'(rdBusy), 32'(vecs[i].eRdBusy));
      checkOutput({tag, " rd_frame_valid"}, 32'(rdValid), 32'(vecs[i].eRdValid));
      checkOutput({tag, " rd_new"}, 32'(rdNew), 32'(vecs[i].eRdNew));
      checkOutput({tag, " wr_drop_cnt"}, 32'(dropCnt), 32'(vecs[i].eDrop));
      checkOutput({tag, " rd_repeat_cnt"}, 32'(repCnt), 32'(vecs[i].eRep));
      if (vecs[i].eRdValid) begin
        checkOutput({tag, " rd_base_addr"}, 32'(rdAddr), 32'(vecs[i].eRdIdx) * 32'h100000);
      end
    end

    // 4-frame ring: eight writer frames with no reader, index wraps after 3.
    applyReset();
    checkZero4("reset2");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tag = $sformatf("n4 frame%0d", k);
      checkOutput({tag, " wr_idx"}, 32'(wrIdx4), 32'(k % 4));
      checkOutput({tag, " wr_base_addr"}, 32'(wrAddr4), 32'(k % 4) * 32'h200000);
      checkOutput({tag, " wr_busy"}, 32'(wrBusy4), 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput({tag, " wr_busy after done"}, 32'(wrBusy4), 32'h0);
    end
    checkOutput("n4 drop after 8 frames", 32'(dropCnt4), 32'h0);

    // Reset mid-frame with a done pulse in flight: everything returns to zero.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("n4 midframe wr_busy", 32'(wrBusy4), 32'h1);
    @(negedge clk);
    resetn  = 1'b0;
    wrStart = 1'b0;
    rdStart = 1'b0;
    wrDone  = 1'b1;
    @(posedge clk);
    #1;
    checkZero4("midreset");
    checkZero3("midreset");

    // A done right after reset is stale; the next reader start must not see a new frame.
    @(negedge clk);
    resetn = 1'b1;
    wrDone = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("post-reset rd_new", 32'(rdNew4), 32'h0);
    checkOutput("post-reset rd_frame_valid", 32'(rdValid4), 32'h0);
    checkOutput("post-reset rd_busy", 32'(rdBusy4), 32'h1);
    checkOutput("post-reset rd_repeat_cnt", 32'(repCnt4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
